// File: rtl/need_decay_gen.sv
// -----------------------------------------------------------------------------
// need_decay_gen
//   Produces the four pet-need levels (hunger, sleep, fun, energy) that feed
//   fsmlevel. Each need loses 1 on its own multiple of a slow base tick and
//   gains ACTION_STEP on the rising edge of its user button. Levels saturate
//   at 0 and MAX_LEVEL.
//
// Ports
//   clk    in   1  system clock
//   reset  in   1  asynchronous, active-high reset
//   feed   in   1  button level, rising edge raises NH
//   sleep  in   1  button level, rising edge raises NS
//   play   in   1  button level, rising edge raises NF
//   rest   in   1  button level, rising edge raises NE
//   NH     out  3  hunger level, 0..MAX_LEVEL
//   NS     out  3  sleep level, 0..MAX_LEVEL
//   NF     out  3  fun level, 0..MAX_LEVEL
//   NE     out  3  energy level, 0..MAX_LEVEL
//   tick   out  1  one-cycle pulse on every base tick (registered)
//   alert  out  1  high while any need is 0 (decoded from registered needs)
// -----------------------------------------------------------------------------
module need_decay_gen #(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int DECAY_H     = 1,
  parameter int DECAY_S     = 2,
  parameter int DECAY_F     = 2,
  parameter int DECAY_E     = 3,
  parameter int ACTION_STEP = 2,
  parameter int MAX_LEVEL   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       feed,
  input  logic       sleep,
  input  logic       play,
  input  logic       rest,
  output logic [2:0] NH,
  output logic [2:0] NS,
  output logic [2:0] NF,
  output logic [2:0] NE,
  output logic       tick,
  output logic       alert
);

  localparam int         PW    = $clog2(TICK_CYCLES);
  localparam logic [3:0] MAX4  = 4'(MAX_LEVEL);
  localparam logic [3:0] STEP4 = 4'(ACTION_STEP);

  // One need's next value: add the action step, remove the decay, clamp.
  // A 4-bit intermediate keeps MAX_LEVEL + ACTION_STEP from wrapping.
  function automatic logic [2:0] next_level(input logic [2:0] lvl,
                                            input logic       inc,
                                            input logic       dec);
    logic [3:0] sum;
    sum = {1'b0, lvl} + (inc ? STEP4 : 4'd0);
    if (dec && (sum != 4'd0)) begin
      sum = sum - 4'd1;
    end else begin
      sum = sum;
    end
    if (sum > MAX4) begin
      sum = MAX4;
    end else begin
      sum = sum;
    end
    return sum[2:0];
  endfunction

  logic [PW-1:0]   r_presc;
  logic            r_tick;
  logic [3:0]      r_btn_q;
  logic [3:0]      w_btn;
  logic [3:0]      w_inc;
  logic [3:0][2:0] w_need;

  assign w_btn = {rest, play, sleep, feed};
  // A press counts once: only the low-to-high transition raises a need.
  assign w_inc = w_btn & ~r_btn_q;

  // Base-tick prescaler; tick is registered one count early so that it is
  // high exactly while the prescaler sits at its terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      if (r_presc == PW'(TICK_CYCLES - 1)) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      r_tick <= (r_presc == PW'(TICK_CYCLES - 2));
    end
  end

  // Button history for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_q <= 4'd0;
    end else begin
      r_btn_q <= w_btn;
    end
  end

  // One decay counter plus level register per need (0=H, 1=S, 2=F, 3=E).
  for (genvar g = 0; g < 4; g++) begin : gen_need
    localparam int D  = (g == 0) ? DECAY_H :
                        (g == 1) ? DECAY_S :
                        (g == 2) ? DECAY_F : DECAY_E;
    localparam int CW = $clog2(D) + 1;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_need;
    logic          w_dec;

    assign w_dec     = r_tick && (r_cnt == CW'(D - 1));
    assign w_need[g] = r_need;

    // Decay counter advances only on tick cycles and wraps after D ticks.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (w_dec) begin
        r_cnt <= '0;
      end else if (r_tick) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end

    // Need level: inc and dec may land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_need <= 3'(MAX_LEVEL);
      end else begin
        r_need <= next_level(r_need, w_inc[g], w_dec);
      end
    end
  end

  assign NH    = w_need[0];
  assign NS    = w_need[1];
  assign NF    = w_need[2];
  assign NE    = w_need[3];
  assign tick  = r_tick;
  assign alert = (w_need[0] == 3'd0) || (w_need[1] == 3'd0) ||
                 (w_need[2] == 3'd0) || (w_need[3] == 3'd0);

endmodule

// File: tb/tb_need_decay_gen.sv
// -----------------------------------------------------------------------------
// tb_need_decay_gen
//   Directed stimulus with hand-computed expected levels. The stimulus side
//   pushes each expected state into a queue; a separate monitor pops and
//   compares it against the DUT outputs.
//   Cycle numbering: "edge n" is the n-th rising clk edge after reset release.
//   With TICK_CYCLES=4, tick is high after edges 3,7,11,... and the decays
//   land on edges 4,8,12,...
// -----------------------------------------------------------------------------
module tb_need_decay_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       feed = 1'b0, sleep = 1'b0, play = 1'b0, rest = 1'b0;
  logic [2:0] NH, NS, NF, NE;
  logic       tick, alert;

  need_decay_gen #(
    .TICK_CYCLES(4), .DECAY_H(1), .DECAY_S(2), .DECAY_F(2), .DECAY_E(3),
    .ACTION_STEP(2), .MAX_LEVEL(5)
  ) dut (
    .clk(clk), .reset(reset),
    .feed(feed), .sleep(sleep), .play(play), .rest(rest),
    .NH(NH), .NS(NS), .NF(NF), .NE(NE),
    .tick(tick), .alert(alert)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [13:0] val;  // {NH,NS,NF,NE,tick,alert}
  } exp_t;

  exp_t sb_q[$];
  int   pushed = 0;
  int   popped = 0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: compares whenever an expectation is pending.
  initial begin
    exp_t        e;
    logic [13:0] act;
    forever begin
      wait (pushed > popped);
      e   = sb_q.pop_front();
      popped++;
      act = {NH, NS, NF, NE, tick, alert};
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got NH=%0d NS=%0d NF=%0d NE=%0d tick=%0b alert=%0b, expected NH=%0d NS=%0d NF=%0d NE=%0d tick=%0b alert=%0b",
                 e.name, act[13:11], act[10:8], act[7:5], act[4:2], act[1], act[0],
                 e.val[13:11], e.val[10:8], e.val[7:5], e.val[4:2], e.val[1], e.val[0]);
      end
    end
  end

  task automatic expect_st(input string nm, input int h, input int s,
                           input int f, input int e, input int t, input int a);
    exp_t x;
    x.name = nm;
    x.val  = {3'(h), 3'(s), 3'(f), 3'(e), 1'(t), 1'(a)};
    sb_q.push_back(x);
    pushed++;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Phase A: async reset, idle decay, underflow, held button.
    reset = 1'b1;
    #1;
    expect_st("reset_async", 5, 5, 5, 5, 0, 0);
    @(negedge clk) reset = 1'b0;

    step(3);  expect_st("a_e3_tick",  5, 5, 5, 5, 1, 0);
    step(1);  expect_st("a_e4",       4, 5, 5, 5, 0, 0);
    step(7);  expect_st("a_e11_tick", 3, 4, 4, 5, 1, 0);
    step(1);  expect_st("a_e12",      2, 4, 4, 4, 0, 0);
    // 13 ticks total: NH floors at 0, NS/NF at 0, NE = 5 - 4 = 1.
    step(40); expect_st("a_e52_floor", 0, 0, 0, 1, 0, 1);

    feed = 1'b1;
    step(1);  expect_st("a_e53_feed",  2, 0, 0, 1, 0, 1);
    step(2);  expect_st("a_e55_hold",  2, 0, 0, 1, 1, 1);
    step(1);  expect_st("a_e56_decay", 1, 0, 0, 1, 0, 1);
    step(2);  expect_st("a_e58_single", 1, 0, 0, 1, 0, 1);
    feed = 1'b0;

    // Phase B: saturation, inc+dec on the same edge, other buttons.
    reset = 1'b1;
    #1;
    expect_st("reset_b", 5, 5, 5, 5, 0, 0);
    @(negedge clk) reset = 1'b0;

    step(4);  expect_st("b_e4", 4, 5, 5, 5, 0, 0);
    feed = 1'b1;
    step(1);  expect_st("b_e5_sat", 5, 5, 5, 5, 0, 0);
    feed = 1'b0;
    step(10); expect_st("b_e15_tick", 3, 4, 4, 4, 1, 0);
    feed = 1'b1;
    step(1);  expect_st("b_e16_incdec", 4, 3, 3, 4, 0, 0);
    feed = 1'b0; sleep = 1'b1; play = 1'b1; rest = 1'b1;
    step(1);  expect_st("b_e17_others", 4, 5, 5, 5, 0, 0);
    sleep = 1'b0; play = 1'b0; rest = 1'b0;
    step(13); expect_st("b_e30_mid", 1, 4, 4, 4, 0, 0);

    // Reset mid-count (prescaler at 2): immediate restore, fresh prescaler.
    reset = 1'b1;
    #1;
    expect_st("reset_mid", 5, 5, 5, 5, 0, 0);
    @(negedge clk) reset = 1'b0;
    step(2);  expect_st("c_e2_notick", 5, 5, 5, 5, 0, 0);
    step(1);  expect_st("c_e3_tick",   5, 5, 5, 5, 1, 0);
    step(1);  expect_st("c_e4",        4, 5, 5, 5, 0, 0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 20 && popped != pushed; i++) #1;
    if (popped != pushed) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", pushed - popped);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
